spi_sram_ctrl: RTL and testbench

SPI-slave command sequencer that sits between the SPI pins and the on-chip SRAM. It deserialises MOSI into a command byte, an address byte and data bytes. It issues single-cycle SRAM write and read strobes, and serialises read data onto MISO. Successive data bytes in one frame auto-increment the address. The block runs entirely in the sck domain, and cs_n frames every transaction.

---
 rtl/spi_sram_ctrl_if.sv | 29 ++
 rtl/spi_sram_ctrl.sv | 164 ++++++++++++++++
 tb/tb_spi_sram_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_sram_ctrl_if.sv
// SRAM-side bus of the SPI command sequencer.
//   master: controller side, drives address/data/strobes and receives read data
//   slave : memory side, returns read data combinationally from sram_addr
interface spi_sram_ctrl_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic              sram_we;
  logic              sram_re;
  logic [DATA_W-1:0] sram_rdata;

  modport master (
    output sram_addr,
    output sram_wdata,
    output sram_we,
    output sram_re,
    input  sram_rdata
  );

  modport slave (
    input  sram_addr,
    input  sram_wdata,
    input  sram_we,
    input  sram_re,
    output sram_rdata
  );
endinterface

// File: rtl/spi_sram_ctrl.sv
// SPI-slave command sequencer in front of an asynchronous-read SRAM.
// Frame: command byte, address byte, then data bytes (write) or a turnaround
// bit followed by read bytes on miso. The address auto-increments per byte.
// Ports:
//   sck, rstn    : SPI clock (all updates on posedge), async active-low reset
//   cs_n         : chip select, active low, frames each transaction
//   mosi / miso  : serial in / registered serial out, MSB first
//   busy         : registered, high whenever the sequencer is not idle
//   sram         : SRAM bus (address, write data, one-cycle we/re strobes, read data)
module spi_sram_ctrl #(
  parameter logic [7:0]  WR_CMD = 8'h02,
  parameter logic [7:0]  RD_CMD = 8'h03,
  parameter int unsigned ADDR_W = 8
) (
  input  logic sck,
  input  logic rstn,
  input  logic cs_n,
  input  logic mosi,
  output logic miso,
  output logic busy,
  spi_sram_ctrl_if.master sram
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned TX_W   = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WR,
    S_RD,
    S_IGNORE
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_W,
    OP_R
  } op_e;

  state_e            state;
  op_e               opcode;
  logic [CNT_W-1:0]  bitcnt;
  logic [BYTE_W-2:0] shreg;   // bits received so far; the 8th arrives live on mosi
  logic [TX_W-1:0]   txcnt;
  logic [BYTE_W-2:0] txsh;    // remaining read bits after the MSB has been driven
  logic [BYTE_W-1:0] rx_byte;
  logic              byte_done;

  // Byte as it would stand after shifting in the current mosi bit.
  assign rx_byte   = {shreg, mosi};
  assign byte_done = (bitcnt == CNT_W'(1));

  // Sequencer: framing, deserialiser, SRAM strobes and miso serialiser.
  always_ff @(posedge sck or negedge rstn) begin
    if (!rstn) begin
      state           <= S_IDLE;
      opcode          <= OP_NONE;
      bitcnt          <= CNT_W'(8);
      shreg           <= '0;
      txcnt           <= '0;
      txsh            <= '0;
      miso            <= 1'b0;
      busy            <= 1'b0;
      sram.sram_addr  <= '0;
      sram.sram_wdata <= '0;
      sram.sram_we    <= 1'b0;
      sram.sram_re    <= 1'b0;
    end else if (cs_n) begin
      // Deselect beats any byte completing on this edge; address/data hold.
      state        <= S_IDLE;
      bitcnt       <= CNT_W'(8);
      miso         <= 1'b0;
      busy         <= 1'b0;
      sram.sram_we <= 1'b0;
      sram.sram_re <= 1'b0;
    end else begin
      busy         <= 1'b1;
      sram.sram_we <= 1'b0;
      case (state)
        // The edge leaving IDLE already carries command bit 7.
        S_IDLE, S_CMD: begin
          shreg <= rx_byte[BYTE_W-2:0];
          if (byte_done) begin
            bitcnt <= CNT_W'(8);
            if (rx_byte == WR_CMD) begin
              state  <= S_ADDR;
              opcode <= OP_W;
            end else if (rx_byte == RD_CMD) begin
              state  <= S_ADDR;
              opcode <= OP_R;
            end else begin
              state  <= S_IGNORE;
            end
          end else begin
            bitcnt <= bitcnt - CNT_W'(1);
            state  <= S_CMD;
          end
        end

        S_ADDR: begin
          shreg <= rx_byte[BYTE_W-2:0];
          if (byte_done) begin
            bitcnt         <= CNT_W'(8);
            sram.sram_addr <= ADDR_W'(rx_byte);
            if (opcode == OP_W) begin
              state <= S_WR;
            end else if (opcode == OP_R) begin
              state        <= S_RD;
              sram.sram_re <= 1'b1;
              txcnt        <= '0;
            end else begin
              state <= S_IGNORE;
            end
          end else begin
            bitcnt <= bitcnt - CNT_W'(1);
          end
        end

        S_WR: begin
          shreg <= rx_byte[BYTE_W-2:0];
          // Advance the address on the edge after a committed write.
          if (sram.sram_we) begin
            sram.sram_addr <= sram.sram_addr + ADDR_W'(1);
          end
          if (byte_done) begin
            bitcnt          <= CNT_W'(8);
            sram.sram_wdata <= rx_byte;
            sram.sram_we    <= 1'b1;
          end else begin
            bitcnt <= bitcnt - CNT_W'(1);
          end
        end

        // First RD edge is the turnaround; each byte load coincides with txcnt==0.
        S_RD: begin
          txcnt <= txcnt + TX_W'(1);
          if (txcnt == '0) begin
            miso           <= sram.sram_rdata[BYTE_W-1];
            txsh           <= sram.sram_rdata[BYTE_W-2:0];
            sram.sram_addr <= sram.sram_addr + ADDR_W'(1);
            sram.sram_re   <= 1'b0;
          end else begin
            miso         <= txsh[BYTE_W-2];
            txsh         <= {txsh[BYTE_W-3:0], 1'b0};
            // Strobe sits in the cycle just before the next load edge.
            sram.sram_re <= (txcnt == TX_W'(7));
          end
        end

        S_IGNORE: begin
          miso <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sram_ctrl.sv
// Directed bench for spi_sram_ctrl: a bit-level SPI master drives frames,
// expected SRAM writes and read bytes go into queues, and monitor processes
// compare them against what the DUT actually produces.
module tb_spi_sram_ctrl;

  logic sck  = 1'b0;
  logic rstn = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
  logic miso;
  logic busy;

  spi_sram_ctrl_if bus ();

  spi_sram_ctrl dut (
    .sck  (sck),
    .rstn (rstn),
    .cs_n (cs_n),
    .mosi (mosi),
    .miso (miso),
    .busy (busy),
    .sram (bus)
  );

  initial forever #5 sck = ~sck;

  // SRAM model: asynchronous read, writes from the DUT or from bench preload.
  logic [7:0] mem [256];
  logic       pre_we = 1'b0;
  logic [7:0] pre_a  = '0;
  logic [7:0] pre_d  = '0;
  assign bus.sram_rdata = mem[bus.sram_addr];
  always @(posedge sck) begin
    if (bus.sram_we)  mem[bus.sram_addr] <= bus.sram_wdata;
    else if (pre_we)  mem[pre_a] <= pre_d;
  end

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        wr_q [$];
  logic [7:0] rd_exp_q [$];
  logic [7:0] rd_obs_q [$];
  int         we_cyc_q [$];
  int         tests = 0;
  int         fails = 0;
  int         cyc   = 0;
  int         re_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge sck) cyc <= cyc + 1;

  // Write monitor: every we pulse must match the next expected write.
  always @(negedge sck) begin
    if (bus.sram_we === 1'b1) begin
      we_cyc_q.push_back(cyc);
      if (wr_q.size() == 0) begin
        check("unexpected_write", 32'(bus.sram_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        check("wr_addr", 32'(bus.sram_addr), 32'(e.a));
        check("wr_data", 32'(bus.sram_wdata), 32'(e.d));
      end
      if (bus.sram_re === 1'b1) check("we_re_exclusive", 32'(1), 32'(0));
    end
    if (bus.sram_re === 1'b1) re_cnt++;
  end

  // Read monitor: bytes assembled by the master vs expected read bytes.
  always @(negedge sck) begin
    if (rd_obs_q.size() > 0) begin
      logic [7:0] o;
      o = rd_obs_q.pop_front();
      if (rd_exp_q.size() == 0) check("unexpected_read", 32'(o), 32'hFFFF_FFFF);
      else                      check("rd_byte", 32'(o), 32'(rd_exp_q.pop_front()));
    end
  end

  task automatic edge_bit(input logic m);
    @(negedge sck);
    cs_n = 1'b0;
    mosi = m;
    @(posedge sck);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) edge_bit(b[7-i]);
  endtask

  task automatic end_frame();
    @(negedge sck);
    cs_n = 1'b1;
    mosi = 1'b0;
    @(posedge sck);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge sck);
    pre_we = 1'b1;
    pre_a  = a;
    pre_d  = d;
    @(negedge sck);
    pre_we = 1'b0;
  endtask

  task automatic read_bytes(input int n);
    logic [7:0] v;
    for (int b = 0; b < n; b++) begin
      v = '0;
      for (int i = 0; i < 8; i++) begin
        edge_bit(1'b1);
        v = {v[6:0], miso};
      end
      rd_obs_q.push_back(v);
    end
  endtask

  initial begin
    int re0;
    int we_n0;

    // Reset state
    repeat (3) @(negedge sck);
    check("rst_miso",  32'(miso), 32'(0));
    check("rst_busy",  32'(busy), 32'(0));
    check("rst_addr",  32'(bus.sram_addr), 32'(0));
    check("rst_wdata", 32'(bus.sram_wdata), 32'(0));
    check("rst_we",    32'(bus.sram_we), 32'(0));
    check("rst_re",    32'(bus.sram_re), 32'(0));
    rstn = 1'b1;
    repeat (2) @(negedge sck);

    // 1: single write 02,10,A5
    wr_q.push_back('{a: 8'h10, d: 8'hA5});
    send_byte(8'h02);
    check("t1_busy", 32'(busy), 32'(1));
    send_byte(8'h10);
    send_byte(8'hA5);
    check("t1_we_e24", 32'(bus.sram_we), 32'(1));
    edge_bit(1'b0);
    check("t1_addr_e25", 32'(bus.sram_addr), 32'h11);
    check("t1_we_e25",   32'(bus.sram_we), 32'(0));
    end_frame();
    check("t1_idle_busy", 32'(busy), 32'(0));
    check("t1_addr_hold", 32'(bus.sram_addr), 32'h11);

    // 2: burst write with address wrap
    we_n0 = we_cyc_q.size();
    wr_q.push_back('{a: 8'hFF, d: 8'h11});
    wr_q.push_back('{a: 8'h00, d: 8'h22});
    send_byte(8'h02);
    send_byte(8'hFF);
    send_byte(8'h11);
    send_byte(8'h22);
    end_frame();
    @(negedge sck);
    check("t2_we_count", 32'(we_cyc_q.size() - we_n0), 32'(2));
    if (we_cyc_q.size() - we_n0 == 2)
      check("t2_we_spacing", 32'(we_cyc_q[we_n0+1] - we_cyc_q[we_n0]), 32'(8));
    check("t2_mem_ff", 32'(mem[8'hFF]), 32'h11);
    check("t2_mem_00", 32'(mem[8'h00]), 32'h22);

    // 3: burst read 3C@40, C3@41
    preload(8'h40, 8'h3C);
    preload(8'h41, 8'hC3);
    rd_exp_q.push_back(8'h3C);
    rd_exp_q.push_back(8'hC3);
    send_byte(8'h03);
    send_byte(8'h40);
    check("t3_re_e16",   32'(bus.sram_re), 32'(1));
    check("t3_addr_e16", 32'(bus.sram_addr), 32'h40);
    check("t3_we_e16",   32'(bus.sram_we), 32'(0));
    read_bytes(2);
    edge_bit(1'b0);
    check("t3_busy", 32'(busy), 32'(1));
    end_frame();
    check("t3_busy_end", 32'(busy), 32'(0));

    // 4: bad opcode 7E is ignored
    re0   = re_cnt;
    we_n0 = we_cyc_q.size();
    send_byte(8'h7E);
    check("t4_busy_e8", 32'(busy), 32'(1));
    send_byte(8'h10);
    send_byte(8'h55);
    check("t4_miso", 32'(miso), 32'(0));
    check("t4_busy", 32'(busy), 32'(1));
    end_frame();
    check("t4_busy_end", 32'(busy), 32'(0));
    check("t4_no_re", 32'(re_cnt - re0), 32'(0));
    check("t4_no_we", 32'(we_cyc_q.size() - we_n0), 32'(0));

    // 5: abort partial data byte, then a normal read
    we_n0 = we_cyc_q.size();
    send_byte(8'h02);
    send_byte(8'h20);
    for (int i = 0; i < 5; i++) edge_bit(1'b1);
    end_frame();
    check("t5_busy", 32'(busy), 32'(0));
    check("t5_no_we", 32'(we_cyc_q.size() - we_n0), 32'(0));
    preload(8'h20, 8'h5A);
    rd_exp_q.push_back(8'h5A);
    send_byte(8'h03);
    send_byte(8'h20);
    check("t5_addr", 32'(bus.sram_addr), 32'h20);
    check("t5_re",   32'(bus.sram_re), 32'(1));
    read_bytes(1);
    edge_bit(1'b1);
    edge_bit(1'b1);

    // 6: async reset mid-read, between edges
    #2;
    rstn = 1'b0;
    #1;
    check("t6_miso",  32'(miso), 32'(0));
    check("t6_busy",  32'(busy), 32'(0));
    check("t6_addr",  32'(bus.sram_addr), 32'(0));
    check("t6_wdata", 32'(bus.sram_wdata), 32'(0));
    check("t6_we",    32'(bus.sram_we), 32'(0));
    check("t6_re",    32'(bus.sram_re), 32'(0));
    @(negedge sck);
    cs_n = 1'b1;
    rstn = 1'b1;

    // Everything expected must have been observed.
    repeat (10) @(negedge sck);
    check("wr_q_drained", 32'(wr_q.size()), 32'(0));
    check("rd_q_drained", 32'(rd_exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
